bldc_commutation_ctrl: RTL and testbench



---
 rtl/bldc_pkg.sv | 59 +++++
 rtl/tick_prescaler.sv | 29 ++
 rtl/bldc_commutation_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_bldc_commutation_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// bldc_pkg: shared definitions for the six-step BLDC commutation sequencer.
// It holds the FSM state encodings, the phase bit-order constants, the
// six-entry commutation table and the step-advance helper.
package bldc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_BRAKE = 3'd4
  } state_t;

  // Gate bit order: bit0 = phase A, bit1 = phase B, bit2 = phase C
  localparam logic [2:0] PH_NONE = 3'b000;
  localparam logic [2:0] PH_A    = 3'b001;
  localparam logic [2:0] PH_B    = 3'b010;
  localparam logic [2:0] PH_C    = 3'b100;
  localparam logic [2:0] PH_ALL  = 3'b111;

  typedef struct packed {
    logic [2:0] h;  // high-side gates
    logic [2:0] l;  // low-side gates
  } gate_pat_t;

  localparam gate_pat_t GATES_OFF = '{h: PH_NONE, l: PH_NONE};
  localparam gate_pat_t BRAKE_PAT = '{h: PH_NONE, l: PH_ALL};

  // Commutation table, one entry per step (high / low)
  localparam gate_pat_t COMM_0 = '{h: PH_A, l: PH_B};
  localparam gate_pat_t COMM_1 = '{h: PH_A, l: PH_C};
  localparam gate_pat_t COMM_2 = '{h: PH_B, l: PH_C};
  localparam gate_pat_t COMM_3 = '{h: PH_B, l: PH_A};
  localparam gate_pat_t COMM_4 = '{h: PH_C, l: PH_A};
  localparam gate_pat_t COMM_5 = '{h: PH_C, l: PH_B};

  function automatic gate_pat_t comm_pattern(input logic [2:0] step);
    gate_pat_t pat;
    case (step)
      3'd0:    pat = COMM_0;
      3'd1:    pat = COMM_1;
      3'd2:    pat = COMM_2;
      3'd3:    pat = COMM_3;
      3'd4:    pat = COMM_4;
      3'd5:    pat = COMM_5;
      default: pat = GATES_OFF;
    endcase
    return pat;
  endfunction

  // Next step modulo 6: dir = 0 counts up, dir = 1 counts down
  function automatic logic [2:0] step_advance(input logic [2:0] step, input logic dir);
    logic [2:0] nxt;
    if (dir) nxt = (step == 3'd0) ? 3'd5 : step - 3'd1;
    else     nxt = (step >= 3'd5) ? 3'd0 : step + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider producing a one-CLK tick enable every
// PRESC_MAX+1 cycles. A synchronous clear holds the count at zero.
module tick_prescaler #(
  parameter int PRESC_MAX = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Count 0..PRESC_MAX and wrap; clear wins over counting
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CW'(PRESC_MAX))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CW'(PRESC_MAX));

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// bldc_commutation_ctrl: six-step BLDC commutation sequencer. A prescaler tick
// paces an ALIGN hold on step 0, then a period ramp from START_PER toward
// TARGET_PER, inserting DEAD_CYC all-off cycles before every new pattern.
// Define BLDC_BRAKE_EN to add the BRAKE input (all low-side gates on).
// ALIGN_TICKS must fit in PER_W bits; DEAD_CYC must be at least 1.
module bldc_commutation_ctrl
  import bldc_pkg::*;
#(
  parameter int PRESC_MAX   = 1000,
  parameter int PER_W       = 16,
  parameter int DEAD_CYC    = 8,
  parameter int ALIGN_TICKS = 500,
  parameter int RAMP_STEP   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
`ifdef BLDC_BRAKE_EN
  input  logic             BRAKE,
`endif
  input  logic [PER_W-1:0] START_PER,
  input  logic [PER_W-1:0] TARGET_PER,
  output logic [2:0]       GATE_H,
  output logic [2:0]       GATE_L,
  output logic [2:0]       STEP,
  output logic             AT_SPEED,
  output logic             BUSY
);

  localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

  state_t           state_q, state_d;
  logic [PER_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [PER_W-1:0] cur_per_q, cur_per_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic [2:0]       step_q, step_d;
  gate_pat_t        gates_q, gates_d, hold_pat;
  logic             at_speed_q, busy_q;
  logic             tick, brake_req, align_done, period_done;
  logic [PER_W-1:0] eff_target, start_eff, per_ramped;

`ifdef BLDC_BRAKE_EN
  assign brake_req = BRAKE;
`else
  assign brake_req = 1'b0;
`endif

  // Period 0 would never end a step, so both period inputs floor at 1
  assign eff_target = (TARGET_PER == '0) ? PER_W'(1) : TARGET_PER;
  assign start_eff  = (START_PER  == '0) ? PER_W'(1) : START_PER;

  // Move cur_per toward eff_target by at most RAMP_STEP
  function automatic logic [PER_W-1:0] ramp_toward(input logic [PER_W-1:0] cur,
                                                   input logic [PER_W-1:0] tgt);
    logic [PER_W-1:0] diff, lim;
    lim = PER_W'(RAMP_STEP);
    if (cur > tgt) begin
      diff = cur - tgt;
      return cur - ((diff > lim) ? lim : diff);
    end else begin
      diff = tgt - cur;
      return cur + ((diff > lim) ? lim : diff);
    end
  endfunction

  assign per_ramped = ramp_toward(cur_per_q, eff_target);

  tick_prescaler #(.PRESC_MAX(PRESC_MAX)) u_presc (
    .CLK  (CLK),
    .RST  (RST),
    .clr  ((state_q == ST_IDLE) || !EN),
    .tick (tick)
  );

  assign align_done  = (state_q == ST_ALIGN) && tick &&
                       (tick_cnt_q == PER_W'(ALIGN_TICKS - 1));
  assign period_done = ((state_q == ST_RAMP) || (state_q == ST_RUN)) && tick &&
                       (tick_cnt_q == cur_per_q - PER_W'(1));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: EN low always wins, brake beats a pending step end
  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves
    // state_d unassigned and infers a latch.
    state_d = state_q;
    if (!EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ALIGN;
        ST_ALIGN: begin
          if (brake_req)       state_d = ST_BRAKE;
          else if (align_done) state_d = ST_RAMP;
        end
        ST_RAMP, ST_RUN: begin
          if (brake_req)        state_d = ST_BRAKE;
          else if (period_done) state_d = (per_ramped == eff_target) ? ST_RUN : ST_RAMP;
        end
`ifdef BLDC_BRAKE_EN
        ST_BRAKE: if (!brake_req) state_d = ST_IDLE;
`endif
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath logic: step advance, period ramp and dead-time sequencing
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    cur_per_d  = cur_per_q;
    dead_d     = dead_q;
    step_d     = step_q;
    gates_d    = gates_q;
    hold_pat   = (state_q == ST_BRAKE) ? BRAKE_PAT : comm_pattern(step_q);

    // Dead-time countdown; the pending pattern appears as it expires
    if (dead_q != '0) begin
      dead_d = dead_q - DW'(1);
      if (dead_q == DW'(1)) gates_d = hold_pat;
    end

    if (state_d == ST_IDLE) begin
      tick_cnt_d = '0;
      cur_per_d  = '0;
      dead_d     = '0;
      step_d     = 3'd0;
      gates_d    = GATES_OFF;
    end else begin
      case (state_q)
        // Leaving all-off cannot shoot through, so step 0 drives at once
        ST_IDLE: begin
          tick_cnt_d = '0;
          dead_d     = '0;
          step_d     = 3'd0;
          gates_d    = comm_pattern(3'd0);
        end
        ST_ALIGN, ST_RAMP, ST_RUN: begin
          if (state_d == ST_BRAKE) begin
            gates_d = GATES_OFF;
            dead_d  = DW'(DEAD_CYC);
          end else if (align_done || period_done) begin
            tick_cnt_d = '0;
            step_d     = step_advance(step_q, DIR);
            gates_d    = GATES_OFF;
            dead_d     = DW'(DEAD_CYC);
            cur_per_d  = (state_q == ST_ALIGN) ? start_eff : per_ramped;
          end else if (tick) begin
            tick_cnt_d = tick_cnt_q + PER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers; reset forces all gates off asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_q <= '0;
      cur_per_q  <= '0;
      dead_q     <= '0;
      step_q     <= 3'd0;
      gates_q    <= GATES_OFF;
      at_speed_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      cur_per_q  <= cur_per_d;
      dead_q     <= dead_d;
      step_q     <= step_d;
      gates_q    <= gates_d;
      at_speed_q <= (state_d == ST_RUN);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign GATE_H   = gates_q.h;
  assign GATE_L   = gates_q.l;
  assign STEP     = step_q;
  assign AT_SPEED = at_speed_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// tb_bldc_commutation_ctrl: directed scenarios followed by randomized stimulus,
// compared every cycle against a cycle-count reference model of the sequencer.
module tb_bldc_commutation_ctrl;

  localparam int PRESC_MAX   = 3;
  localparam int PER_W       = 16;
  localparam int DEAD_CYC    = 2;
  localparam int ALIGN_TICKS = 4;
  localparam int RAMP_STEP   = 4;
  localparam int TICK_CLK    = PRESC_MAX + 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             DIR = 1'b0;
  logic             BRAKE = 1'b0;
  logic [PER_W-1:0] START_PER = 16'd20;
  logic [PER_W-1:0] TARGET_PER = 16'd10;
  logic [2:0]       GATE_H, GATE_L, STEP;
  logic             AT_SPEED, BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  bldc_commutation_ctrl #(
    .PRESC_MAX   (PRESC_MAX),
    .PER_W       (PER_W),
    .DEAD_CYC    (DEAD_CYC),
    .ALIGN_TICKS (ALIGN_TICKS),
    .RAMP_STEP   (RAMP_STEP)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .DIR        (DIR),
`ifdef BLDC_BRAKE_EN
    .BRAKE      (BRAKE),
`endif
    .START_PER  (START_PER),
    .TARGET_PER (TARGET_PER),
    .GATE_H     (GATE_H),
    .GATE_L     (GATE_L),
    .STEP       (STEP),
    .AT_SPEED   (AT_SPEED),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each step lasts exactly period*TICK_CLK cycles, the align hold
  // ALIGN_TICKS*TICK_CLK cycles; every advance blanks the gates for DEAD_CYC.
  typedef enum int {M_IDLE, M_ALIGN, M_RAMP, M_RUN, M_BRAKE} m_phase_t;
  m_phase_t m_phase;
  int m_elapsed, m_seg_len, m_step, m_per, m_dead;
  int h_tab[6] = '{1, 1, 2, 2, 4, 4};
  int l_tab[6] = '{2, 4, 4, 1, 1, 2};

  task automatic model_reset();
    m_phase = M_IDLE; m_elapsed = 0; m_seg_len = 0; m_step = 0; m_per = 0; m_dead = 0;
  endtask

  // Applies one rising edge with the inputs currently driven
  task automatic model_edge();
    int tgt, d;
    if (!EN) begin
      model_reset();
    end else if (m_phase == M_IDLE) begin
      m_phase = M_ALIGN; m_step = 0; m_elapsed = 0; m_dead = 0;
      m_seg_len = ALIGN_TICKS * TICK_CLK;
    end else if (m_phase == M_BRAKE) begin
      if (!BRAKE) model_reset();
      else if (m_dead > 0) m_dead--;
    end else if (BRAKE) begin
      m_phase = M_BRAKE; m_dead = DEAD_CYC;
    end else begin
      m_elapsed++;
      if (m_dead > 0) m_dead--;
      if (m_elapsed == m_seg_len) begin
        tgt = (int'(TARGET_PER) < 1) ? 1 : int'(TARGET_PER);
        if (m_phase == M_ALIGN) begin
          m_per = (int'(START_PER) < 1) ? 1 : int'(START_PER);
          m_phase = M_RAMP;
        end else begin
          d = tgt - m_per;
          if (d > RAMP_STEP) d = RAMP_STEP;
          if (d < -RAMP_STEP) d = -RAMP_STEP;
          m_per += d;
          m_phase = (m_per == tgt) ? M_RUN : M_RAMP;
        end
        m_step = DIR ? (m_step + 5) % 6 : (m_step + 1) % 6;
        m_seg_len = m_per * TICK_CLK;
        m_elapsed = 0;
        m_dead = DEAD_CYC;
      end
    end
  endtask

  task automatic compare_all();
    int eh, el;
    if (m_phase == M_IDLE || m_dead > 0) begin eh = 0; el = 0; end
    else if (m_phase == M_BRAKE)         begin eh = 0; el = 7; end
    else                                 begin eh = h_tab[m_step]; el = l_tab[m_step]; end
    check("gate_h", GATE_H, eh);
    check("gate_l", GATE_L, el);
    check("step", STEP, m_step);
    check("at_speed", AT_SPEED, m_phase == M_RUN);
    check("busy", BUSY, m_phase != M_IDLE);
    check("no_shoot_through", GATE_H & GATE_L, 0);
  endtask

  // One clock: edge, model update, then sample 1 time unit later
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  // Runs until STEP changes (bounded) and returns the cycle count taken
  task automatic wait_step_change(output int n);
    logic [2:0] prev;
    prev = STEP;
    n = 0;
    while (STEP == prev && n < 400) begin
      cycle();
      n++;
    end
    check("step_changed", STEP != prev, 1);
  endtask

  // Asynchronous reset pulse mid-cycle: gates must drop before the next edge
  task automatic async_reset();
    #2 RST = 1'b1;
    #1;
    model_reset();
    check("async_rst_gate_h", GATE_H, 0);
    check("async_rst_gate_l", GATE_L, 0);
    @(posedge CLK);
    #1;
    compare_all();
    RST = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    compare_all();
    RST = 1'b0;

    // Start + ramp: align 16 CLK, then 20,16,12,10 ticks per step
    EN = 1'b1;
    cycle();
    check("busy_after_en", BUSY, 1);
    wait_step_change(n);  check("align_cycles", n, 16);
    check("step_after_align", STEP, 1);
    wait_step_change(n);  check("per20_cycles", n, 80);
    wait_step_change(n);  check("per16_cycles", n, 64);
    check("not_at_speed", AT_SPEED, 0);
    wait_step_change(n);  check("per12_cycles", n, 48);
    check("at_speed_third_adv", AT_SPEED, 1);
    check("dead_h_zero", GATE_H, 0);
    wait_step_change(n);  check("per10_cycles", n, 40);

    // Direction: DIR=1 from step 0 goes to step 5 (C/B)
    EN = 1'b0; cycle();
    DIR = 1'b1; EN = 1'b1; cycle();
    wait_step_change(n);
    check("dir_down_step", STEP, 5);
    cycle(); cycle();
    check("dir_down_h", GATE_H, 3'b100);
    check("dir_down_l", GATE_L, 3'b010);
    // DIR toggled mid-period has no effect until the boundary
    repeat (30) begin DIR = ~DIR; cycle(); end
    DIR = 1'b1;

    // Abort during dead time, then restart from ALIGN
    wait_step_change(n);
    EN = 1'b0; cycle();
    check("abort_gate_h", GATE_H, 0);
    check("abort_step", STEP, 0);
    EN = 1'b1; cycle();
    check("restart_busy", BUSY, 1);
    check("restart_gate_h", GATE_H, 3'b001);

    // Zero target: START 2 -> settles at 1 tick per step
    EN = 1'b0; cycle();
    START_PER = 16'd2; TARGET_PER = 16'd0; DIR = 1'b0; EN = 1'b1; cycle();
    wait_step_change(n);  check("zt_align", n, 16);
    wait_step_change(n);  check("zt_per2", n, 8);
    repeat (3) begin
      wait_step_change(n);  check("zt_per1", n, 4);
    end

`ifdef BLDC_BRAKE_EN
    // Brake from RUN: DEAD_CYC off, then all low sides on; release -> IDLE
    START_PER = 16'd3; TARGET_PER = 16'd3; cycle();
    wait_step_change(n); wait_step_change(n); repeat (3) cycle();
    BRAKE = 1'b1;
    cycle(); check("brake_dead1_l", GATE_L, 0);
    cycle(); check("brake_dead2_l", GATE_L, 0);
    cycle(); check("brake_l", GATE_L, 3'b111); check("brake_h", GATE_H, 0);
    BRAKE = 1'b0; cycle(); check("brake_release_busy", BUSY, 0);
`endif

    // Randomized run: DIR every cycle, occasional period changes, EN drops, resets
    START_PER = 16'd6; TARGET_PER = 16'd3;
    for (int i = 0; i < 6000; i++) begin
      DIR = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) TARGET_PER = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 199) == 0) START_PER  = 16'($urandom_range(0, 12));
`ifdef BLDC_BRAKE_EN
      if ($urandom_range(0, 299) == 0) BRAKE = ~BRAKE;
`endif
      if ($urandom_range(0, 399) == 0) EN = 1'b0;
      else if (!EN && $urandom_range(0, 2) == 0) EN = 1'b1;
      if ($urandom_range(0, 1499) == 0) async_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
